// File: rtl/dut_stimulus_sequencer.sv
// dut_stimulus_sequencer
//   Drives a captured 8-bit stimulus word onto a 2-input gate DUT as four
//   2-bit pairs, pair 0 first. Each pair is held for SETTLE_CYCLES clocks.
//   The DUT output then passes through a 2-flop synchronizer and is sampled,
//   which builds a 4-bit truth-table result.
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        begin a run (accepted only when idle)
//   vec_in       stimulus word, pair k = vec_in[2k+1:2k]
//   dut_out      DUT output, asynchronous to clk
//   dut_pinout   registered drive to the DUT inputs
//   busy         run in progress
//   done         one-cycle completion pulse
//   result       bit k = sampled DUT output for pair k
//   result_valid result holds a completed run
module dut_stimulus_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned NUM_PAIRS     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] vec_in,
    input  logic       dut_out,
    output logic [1:0] dut_pinout,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       result_valid
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StDrive  = 3'd1;
    localparam logic [2:0] StSettle = 3'd2;
    localparam logic [2:0] StSample = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    localparam logic [7:0] CntLast = 8'(SETTLE_CYCLES - 1);
    localparam logic [1:0] IdxLast = 2'(NUM_PAIRS - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] vec_q, vec_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] pin_q, pin_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] result_q, result_d;
    logic       valid_q, valid_d;
    logic [1:0] sync_q;
    logic       dut_s;

    assign dut_s = sync_q[1];

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        pin_d    = pin_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    vec_d    = vec_in;
                    idx_d    = 2'd0;
                    result_d = 4'h0;
                    valid_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = StDrive;
                end
            end
            StDrive: begin
                // {idx,0} is the bit offset 2*idx of pair idx.
                pin_d   = vec_q[{idx_q, 1'b0} +: 2];
                cnt_d   = 8'd0;
                state_d = StSettle;
            end
            StSettle: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CntLast) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                result_d[idx_q] = dut_s;
                if (idx_q == IdxLast) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = StDrive;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                pin_d   = 2'b00;
                idx_d   = 2'd0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            vec_q    <= 8'h00;
            idx_q    <= 2'd0;
            cnt_q    <= 8'd0;
            pin_q    <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 4'h0;
            valid_q  <= 1'b0;
            sync_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            pin_q    <= pin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            sync_q   <= {sync_q[0], dut_out};
        end
    end

    assign dut_pinout   = pin_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_dut_stimulus_sequencer.sv
// Bench for dut_stimulus_sequencer: three instances (settle 16, 2, 8) share the
// stimulus; each drives its own delayed gate model.
module tb_dut_stimulus_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] vec_in;
    int         gate_sel;
    int         checks = 0;
    int         errors = 0;

    logic [1:0] m_pin, s_pin, l_pin;
    logic       m_busy, s_busy, l_busy, m_done, s_done, l_done;
    logic [3:0] m_res, s_res, l_res;
    logic       m_val, s_val, l_val;
    logic       m_dout, s_dout, l_dout;

    bit   [1:0] hist_m [8];
    bit   [1:0] hist_s [8];
    bit   [1:0] hist_l [8];

    logic [1:0] pin_log [0:199];
    logic       busy_log [0:199];

    always #5 clk = ~clk;

    function automatic logic gate_fn(input int g, input logic [1:0] p);
        case (g)
            0: return p[1] & p[0];
            1: return p[1] ^ p[0];
            2: return ~(p[1] & p[0]);
            default: return p[1] | p[0];
        endcase
    endfunction

    // Gate model: output follows the pin value from D cycles earlier.
    always @(posedge clk) begin
        hist_m[0] <= m_pin;
        hist_s[0] <= s_pin;
        hist_l[0] <= l_pin;
        for (int i = 1; i < 8; i++) begin
            hist_m[i] <= hist_m[i-1];
            hist_s[i] <= hist_s[i-1];
            hist_l[i] <= hist_l[i-1];
        end
    end
    assign m_dout = gate_fn(gate_sel, hist_m[2]);  // delay 3
    assign s_dout = gate_fn(gate_sel, hist_s[4]);  // delay 5
    assign l_dout = gate_fn(gate_sel, hist_l[4]);  // delay 5

    dut_stimulus_sequencer #(.SETTLE_CYCLES(16), .NUM_PAIRS(4)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_in(vec_in), .dut_out(m_dout),
        .dut_pinout(m_pin), .busy(m_busy), .done(m_done), .result(m_res),
        .result_valid(m_val)
    );
    dut_stimulus_sequencer #(.SETTLE_CYCLES(2), .NUM_PAIRS(4)) u_short (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_in(vec_in), .dut_out(s_dout),
        .dut_pinout(s_pin), .busy(s_busy), .done(s_done), .result(s_res),
        .result_valid(s_val)
    );
    dut_stimulus_sequencer #(.SETTLE_CYCLES(8), .NUM_PAIRS(4)) u_mid (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_in(vec_in), .dut_out(l_dout),
        .dut_pinout(l_pin), .busy(l_busy), .done(l_done), .result(l_res),
        .result_valid(l_val)
    );

    // Reference: with start accepted at edge 0, pair p is driven from cycle
    // 1+p*(sc+2) and sampled at edge (p+1)*(sc+2). Through a delay-d gate and a
    // 2-flop synchronizer, that sample sees the pins of cycle (p+1)*(sc+2)-3-d.
    function automatic logic [3:0] exp_result(input logic [7:0] vec, input int g,
                                              input int sc, input int d);
        logic [3:0] r;
        logic [7:0] sh;
        logic [1:0] pin;
        int c, q;
        for (int p = 0; p < 4; p++) begin
            c = (p + 1) * (sc + 2) - 3 - d;
            if (c < 1) begin
                pin = 2'b00;
            end else begin
                q   = (c - 1) / (sc + 2);
                sh  = vec >> (2 * q);
                pin = sh[1:0];
            end
            r[p] = gate_fn(g, pin);
        end
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Pulse start, then log main-instance outputs each cycle until done or timeout.
    task automatic run_main(input logic [7:0] vec, output int done_at, output int n_done,
                            output logic busy0, output logic valid0,
                            output logic [3:0] res0, output logic done0);
        done_at = -1;
        n_done  = 0;
        @(negedge clk);
        vec_in = vec;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        busy0  = m_busy;
        valid0 = m_val;
        res0   = m_res;
        done0  = m_done;
        for (int n = 1; n < 150; n++) begin
            @(posedge clk);
            #1;
            pin_log[n]  = m_pin;
            busy_log[n] = m_busy;
            if (m_done === 1'b1) begin
                n_done++;
                done_at = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (m_pin !== 2'b00) begin errors++; $display("FAIL reset_pin got=%b exp=00", m_pin); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", m_busy); end
        checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", m_done); end
        checks++; if (m_res !== 4'h0) begin errors++; $display("FAIL reset_result got=%b exp=0000", m_res); end
        checks++; if (m_val !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_val); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_and();
        int da, nd; logic b0, v0, d0; logic [3:0] r0;
        gate_sel = 0;
        run_main(8'b11_10_01_00, da, nd, b0, v0, r0, d0);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL and_busy_start got=%b exp=1", b0); end
        checks++; if (da !== 73) begin errors++; $display("FAIL and_done_cycle got=%0d exp=73", da); end
        if (da == 73) begin
            checks++; if (pin_log[1] !== 2'b00) begin errors++; $display("FAIL and_pin0 got=%b exp=00", pin_log[1]); end
            checks++; if (pin_log[19] !== 2'b01) begin errors++; $display("FAIL and_pin1 got=%b exp=01", pin_log[19]); end
            checks++; if (pin_log[37] !== 2'b10) begin errors++; $display("FAIL and_pin2 got=%b exp=10", pin_log[37]); end
            checks++; if (pin_log[72] !== 2'b11) begin errors++; $display("FAIL and_pin3 got=%b exp=11", pin_log[72]); end
            checks++; if (pin_log[73] !== 2'b00) begin errors++; $display("FAIL and_pin_end got=%b exp=00", pin_log[73]); end
            checks++; if (busy_log[72] !== 1'b1 || busy_log[73] !== 1'b0) begin
                errors++; $display("FAIL and_busy_span got=%b%b exp=10", busy_log[72], busy_log[73]); end
        end
        checks++; if (m_res !== 4'b1000) begin errors++; $display("FAIL and_result got=%b exp=1000", m_res); end
        checks++; if (m_val !== 1'b1) begin errors++; $display("FAIL and_valid got=%b exp=1", m_val); end
    endtask

    task automatic test_xor();
        int da, nd; logic b0, v0, d0; logic [3:0] r0;
        gate_sel = 1;
        repeat (8) @(negedge clk);
        run_main(8'b11_10_01_00, da, nd, b0, v0, r0, d0);
        checks++; if (m_res !== 4'b0110) begin errors++; $display("FAIL xor_result got=%b exp=0110", m_res); end
        checks++; if (m_val !== 1'b1) begin errors++; $display("FAIL xor_valid got=%b exp=1", m_val); end
        repeat (4) @(negedge clk);
        checks++; if (m_res !== 4'b0110) begin errors++; $display("FAIL xor_hold got=%b exp=0110", m_res); end
        run_main(8'h5a, da, nd, b0, v0, r0, d0);
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL xor_valid_drop got=%b exp=0", v0); end
        checks++; if (r0 !== 4'h0) begin errors++; $display("FAIL xor_result_clear got=%b exp=0000", r0); end
    endtask

    task automatic test_hold_start();
        int nd, da;
        gate_sel = 0;
        nd = 0;
        da = -1;
        repeat (8) @(negedge clk);
        vec_in = 8'b11_10_01_00;
        start  = 1'b1;
        @(posedge clk);
        for (int n = 1; n < 150; n++) begin
            @(posedge clk);
            #1;
            if (n == 30) vec_in = 8'hff;
            if (m_done === 1'b1) begin
                nd++;
                da    = n;
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (m_done === 1'b1) nd++;
        end
        checks++; if (nd !== 1) begin errors++; $display("FAIL hold_done_count got=%0d exp=1", nd); end
        checks++; if (da !== 73) begin errors++; $display("FAIL hold_done_cycle got=%0d exp=73", da); end
        checks++; if (m_res !== 4'b1000) begin errors++; $display("FAIL hold_result got=%b exp=1000", m_res); end
    endtask

    task automatic test_reset_mid();
        int nd;
        nd = 0;
        gate_sel = 3;
        repeat (8) @(negedge clk);
        vec_in = 8'b10_10_10_10;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        repeat (45) @(posedge clk);
        @(negedge clk);
        checks++; if (m_pin !== 2'b10) begin errors++; $display("FAIL rmid_pin_before got=%b exp=10", m_pin); end
        rst_n = 1'b0;
        #1;
        checks++; if (m_pin !== 2'b00) begin errors++; $display("FAIL rmid_pin got=%b exp=00", m_pin); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", m_busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (m_done === 1'b1) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL rmid_done got=%0d exp=0", nd); end
        checks++; if (m_res !== 4'h0) begin errors++; $display("FAIL rmid_result got=%b exp=0000", m_res); end
        checks++; if (m_val !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", m_val); end
    endtask

    task automatic test_settle();
        int sd, ld;
        logic [3:0] s_exp, l_exp;
        sd = 0;
        ld = 0;
        gate_sel = 0;
        do_reset();
        vec_in = 8'b11_10_01_00;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        for (int n = 1; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (s_done === 1'b1) sd++;
            if (l_done === 1'b1) ld++;
        end
        s_exp = exp_result(8'b11_10_01_00, 0, 2, 5);
        l_exp = exp_result(8'b11_10_01_00, 0, 8, 5);
        checks++; if (sd !== 1 || ld !== 1) begin errors++; $display("FAIL settle_dones got=%0d,%0d exp=1,1", sd, ld); end
        checks++; if (s_res !== s_exp) begin errors++; $display("FAIL settle_short got=%b exp=%b", s_res, s_exp); end
        checks++; if (s_res === 4'b1000) begin errors++; $display("FAIL settle_short_stale got=%b exp=not 1000", s_res); end
        checks++; if (l_res !== 4'b1000) begin errors++; $display("FAIL settle_mid got=%b exp=1000", l_res); end
    endtask

    task automatic test_back_to_back();
        int da, nd; logic b0, v0, d0; logic [3:0] r0;
        do_reset();
        gate_sel = 2;
        run_main(8'b11_10_01_00, da, nd, b0, v0, r0, d0);
        checks++; if (m_res !== 4'b0111) begin errors++; $display("FAIL b2b_nand got=%b exp=0111", m_res); end
        checks++; if (da !== 73) begin errors++; $display("FAIL b2b_done1_cycle got=%0d exp=73", da); end
        gate_sel = 3;
        run_main(8'b11_10_01_00, da, nd, b0, v0, r0, d0);
        checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL b2b_done_width got=%b exp=0", d0); end
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", b0); end
        checks++; if (da !== 73) begin errors++; $display("FAIL b2b_done2_cycle got=%0d exp=73", da); end
        checks++; if (m_res !== 4'b1110) begin errors++; $display("FAIL b2b_or got=%b exp=1110", m_res); end
        @(posedge clk);
        #1;
        checks++; if (m_done !== 1'b0) begin errors++; $display("FAIL b2b_done2_width got=%b exp=0", m_done); end
    endtask

    task automatic test_random();
        int da, nd, g; logic b0, v0, d0; logic [3:0] r0, ex;
        logic [7:0] v;
        for (int it = 0; it < 8; it++) begin
            v = 8'($urandom);
            g = int'($urandom_range(0, 3));
            gate_sel = g;
            repeat (1 + $urandom_range(0, 3)) @(negedge clk);
            run_main(v, da, nd, b0, v0, r0, d0);
            ex = exp_result(v, g, 16, 3);
            checks++; if (m_res !== ex) begin errors++; $display("FAIL rand_result vec=%h gate=%0d got=%b exp=%b", v, g, m_res, ex); end
            checks++; if (da !== 73) begin errors++; $display("FAIL rand_done_cycle got=%0d exp=73", da); end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        vec_in   = 8'h00;
        gate_sel = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        test_reset();
        test_and();
        test_xor();
        test_hold_start();
        test_reset_mid();
        test_settle();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
